// File: rtl/phv_queue_dispatch.sv
// phv_queue_dispatch: delivers each PHV to every queue in its one-hot mask, holding it until
// all selected queues take it or the wait limit abandons the stragglers.
module phv_queue_dispatch #(
   parameter int PHV_LEN      = 1024,
   parameter int C_NUM_QUEUES = 4,
   parameter int QSEL_OFF     = 141,
   parameter int MAX_WAIT     = 1024,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PHV_LEN-1:0]      phv_in,
   input  logic                    phv_in_valid,
   output logic                    phv_in_ready,
   output logic [PHV_LEN-1:0]      phv_out,
   output logic [C_NUM_QUEUES-1:0] phv_out_valid,
   input  logic [C_NUM_QUEUES-1:0] phv_out_ready,
   output logic                    busy,
   output logic [CNT_WIDTH-1:0]    pkt_cnt,
   output logic [CNT_WIDTH-1:0]    mcast_cnt,
   output logic [CNT_WIDTH-1:0]    drop_cnt,
   output logic [CNT_WIDTH-1:0]    timeout_cnt
);
   localparam int WW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

   logic [PHV_LEN-1:0]      r_phv_q;
   logic [C_NUM_QUEUES-1:0] r_pend;
   logic [WW-1:0]           r_wcnt;
   logic [CNT_WIDTH-1:0]    r_pkt, r_mcast, r_drop, r_tout;
   logic [C_NUM_QUEUES-1:0] w_mask, w_left;
   logic                    w_done, w_acc, w_load, w_multi, w_to;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
      return (en && !(&c)) ? c + 1'b1 : c;
   endfunction

   always_comb begin
      w_mask  = phv_in[QSEL_OFF +: C_NUM_QUEUES];
      w_left  = r_pend & ~phv_out_ready;
      w_done  = (w_left == '0);
      w_acc   = phv_in_valid && phv_in_ready;
      w_load  = w_acc && (w_mask != '0);
      w_multi = ((w_mask & (w_mask - 1'b1)) != '0);
      // stragglers remain after this cycle's deliveries and the limit, counted from load, is reached
      w_to    = (MAX_WAIT != 0) && !w_done && (r_wcnt == WW'(MAX_WAIT - 1));
   end

   assign phv_in_ready  = (r_pend == '0) || w_done;
   assign phv_out       = r_phv_q;
   assign phv_out_valid = r_pend;
   assign busy          = (r_pend != '0);
   assign pkt_cnt       = r_pkt;
   assign mcast_cnt     = r_mcast;
   assign drop_cnt      = r_drop;
   assign timeout_cnt   = r_tout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phv_q <= '0;
         r_pend  <= '0;
         r_wcnt  <= '0;
         r_pkt   <= '0;
         r_mcast <= '0;
         r_drop  <= '0;
         r_tout  <= '0;
      end else begin
         if (w_load) begin
            r_phv_q <= phv_in;
            r_pend  <= w_mask;
            r_wcnt  <= '0;
         end else if (w_to) begin
            r_pend  <= '0;
            r_wcnt  <= '0;
         end else begin
            r_pend  <= w_left;
            r_wcnt  <= (w_left != '0) ? r_wcnt + 1'b1 : '0;
         end
         r_pkt   <= sat_inc(r_pkt, w_load);
         r_mcast <= sat_inc(r_mcast, w_load && w_multi);
         r_drop  <= sat_inc(r_drop, w_acc && (w_mask == '0));
         r_tout  <= sat_inc(r_tout, w_to);
      end
   end
endmodule

// File: tb/tb_phv_queue_dispatch.sv
// tb_phv_queue_dispatch: directed-step bench with immediate assertions on every comparison.
module tb_phv_queue_dispatch;
   localparam int PL = 1024;
   localparam int NQ = 4;
   localparam int QO = 141;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [PL-1:0] phv_in;
   logic          phv_in_valid;
   logic          phv_in_ready;
   logic [PL-1:0] phv_out;
   logic [NQ-1:0] phv_out_valid;
   logic [NQ-1:0] phv_out_ready;
   logic          busy;
   logic [CW-1:0] pkt_cnt, mcast_cnt, drop_cnt, timeout_cnt;
   int            n_chk = 0;
   int            n_err = 0;

   phv_queue_dispatch #(.PHV_LEN(PL), .C_NUM_QUEUES(NQ), .QSEL_OFF(QO), .MAX_WAIT(4), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
      .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready), .busy(busy),
      .pkt_cnt(pkt_cnt), .mcast_cnt(mcast_cnt), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [PL-1:0] mk(input logic [NQ-1:0] m, input logic [31:0] t);
      logic [PL-1:0] p;
      p = '0;
      p[QO +: NQ] = m;
      p[31:0] = t;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; phv_in = '0; phv_in_valid = 1'b0; phv_out_ready = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_in_ready", phv_in_ready, 1);
      chk("rst_valid", phv_out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_phv_out", phv_out, 0);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_cnts", {mcast_cnt, drop_cnt, timeout_cnt}, 0);

      // unicast streaming, 8 back-to-back
      phv_out_ready = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         phv_in = mk(4'b0001, k + 1); phv_in_valid = 1'b1;
         #1;
         chk("uni_in_ready", phv_in_ready, 1);
         if (k > 0) begin
            chk("uni_valid", phv_out_valid, 4'b0001);
            chk("uni_tag", phv_out[31:0], k);
         end
         tick();
      end
      phv_in_valid = 1'b0;
      #1;
      chk("uni_valid_last", phv_out_valid, 4'b0001);
      chk("uni_out_last", phv_out, mk(4'b0001, 8));
      tick();
      chk("uni_valid_off", phv_out_valid, 0);
      chk("uni_pkt", pkt_cnt, 8);
      chk("uni_mcast", mcast_cnt, 0);

      // staggered multicast
      phv_out_ready = '0; phv_in = mk(4'b1011, 100); phv_in_valid = 1'b1;
      #1;
      chk("mc_accept", phv_in_ready, 1);
      tick();
      phv_in_valid = 1'b0; phv_out_ready = 4'b0001;
      #1;
      chk("mc_v1", phv_out_valid, 4'b1011);
      chk("mc_r1", phv_in_ready, 0);
      tick();
      phv_out_ready = 4'b1000;
      #1;
      chk("mc_v2", phv_out_valid, 4'b1010);
      chk("mc_r2", phv_in_ready, 0);
      tick();
      phv_out_ready = 4'b0010;
      #1;
      chk("mc_v3", phv_out_valid, 4'b0010);
      chk("mc_r3", phv_in_ready, 1);
      tick();
      phv_out_ready = '0;
      #1;
      chk("mc_v4", phv_out_valid, 0);
      chk("mc_mcast", mcast_cnt, 1);
      chk("mc_pkt", pkt_cnt, 9);

      // zero mask while a PHV is held and finishing
      phv_in = mk(4'b0100, 200); phv_in_valid = 1'b1;
      tick();
      phv_in = mk(4'b0000, 300); phv_out_ready = 4'b0100;
      #1;
      chk("zm_held", phv_out_valid, 4'b0100);
      chk("zm_ready", phv_in_ready, 1);
      tick();
      phv_in_valid = 1'b0; phv_out_ready = '0;
      #1;
      chk("zm_valid", phv_out_valid, 0);
      chk("zm_drop", drop_cnt, 1);
      chk("zm_phv_kept", phv_out, mk(4'b0100, 200));
      chk("zm_pkt", pkt_cnt, 10);

      // timeout after 4 cycles
      phv_in = mk(4'b0100, 400); phv_in_valid = 1'b1;
      tick();
      phv_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("to_valid", phv_out_valid, 4'b0100);
         chk("to_busy_ready", phv_in_ready, 0);
         tick();
      end
      phv_in = mk(4'b0001, 500); phv_in_valid = 1'b1;
      #1;
      chk("to_dropped", phv_out_valid, 0);
      chk("to_cnt", timeout_cnt, 1);
      chk("to_next_ready", phv_in_ready, 1);
      tick();
      phv_in_valid = 1'b0; phv_out_ready = 4'b0001;
      #1;
      chk("to_next_valid", phv_out_valid, 4'b0001);
      chk("to_next_tag", phv_out[31:0], 500);
      tick();
      phv_out_ready = '0;
      #1;
      chk("to_next_done", phv_out_valid, 0);
      chk("to_pkt", pkt_cnt, 12);

      // back-to-back handoff under backpressure
      phv_in = mk(4'b0010, 600); phv_in_valid = 1'b1;
      tick();
      phv_in = mk(4'b0001, 700);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bb_wait_ready", phv_in_ready, 0);
         chk("bb_wait_tag", phv_out[31:0], 600);
         tick();
      end
      phv_out_ready = 4'b0010;
      #1;
      chk("bb_handoff_ready", phv_in_ready, 1);
      tick();
      phv_in_valid = 1'b0; phv_out_ready = '0;
      #1;
      chk("bb_new_valid", phv_out_valid, 4'b0001);
      chk("bb_new_tag", phv_out[31:0], 700);
      chk("bb_tout_none", timeout_cnt, 1);
      chk("bb_pkt", pkt_cnt, 14);

      // reset mid-hold
      tick();
      phv_in = mk(4'b1100, 800); phv_in_valid = 1'b1;
      #1;
      chk("rs_busy_before", phv_out_valid, 4'b0001);
      phv_out_ready = 4'b0001;
      tick();
      phv_in_valid = 1'b0; phv_out_ready = '0;
      #1;
      chk("rs_hold", phv_out_valid, 4'b1100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rs_valid", phv_out_valid, 0);
      chk("rs_ready", phv_in_ready, 1);
      chk("rs_busy", busy, 0);
      chk("rs_phv_out", phv_out, 0);
      chk("rs_cnts", {pkt_cnt, mcast_cnt, drop_cnt, timeout_cnt}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
